// File: rtl/reset_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// reset_seq_pkg
// Shared definitions for the reset sequencer slice: the FSM state encoding
// and the default timing parameters used by the top-level module.
// No ports; imported with "import reset_seq_pkg::*;".
// ---------------------------------------------------------------------------
package reset_seq_pkg;

  // Sequencer states, 2-bit encoding
  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } seq_state_e;

  // Defaults sized for a 48 MHz global clock
  localparam int unsigned DEFAULT_LOCK_STABLE = 1024;
  localparam int unsigned DEFAULT_RESET_HOLD  = 16;
  localparam int unsigned DEFAULT_TICK_DIV    = 48;

endpackage

// File: rtl/reset_sequencer_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer bringing a single asynchronous bit into the clk
// domain. Both flops clear to 0 on reset, so a synchronized "locked" reads as
// not-locked until two clean samples have been taken.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset
//   d     - asynchronous input bit
//   q     - synchronized output (second flop)
// ---------------------------------------------------------------------------
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // First flop may go metastable; the second gives it a full cycle to settle
  // before anything downstream looks at the value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// ---------------------------------------------------------------------------
// reset_sequencer
// Waits for the PLL to report lock, debounces the lock for LOCK_STABLE cycles,
// holds the system reset for RESET_HOLD more cycles, then releases it and
// runs a microsecond tick. Losing lock at any point restarts the sequence;
// lock losses seen while running are counted (saturating).
// Ports:
//   global_clock    - single 48 MHz clock, all state on its rising edge
//   reset_n         - asynchronous active-low reset
//   locked          - PLL lock, asynchronous to global_clock
//   sys_reset_n     - registered active-low system reset
//   ready           - high exactly while in RUN
//   us_tick         - one-cycle pulse every TICK_DIV cycles while in RUN
//   lock_loss_count - RUN-to-WAIT_LOCK transitions from lock loss, sat. 255
// ---------------------------------------------------------------------------
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned LOCK_STABLE = DEFAULT_LOCK_STABLE,
  parameter int unsigned RESET_HOLD  = DEFAULT_RESET_HOLD,
  parameter int unsigned TICK_DIV    = DEFAULT_TICK_DIV
) (
  input  logic       global_clock,
  input  logic       reset_n,
  input  logic       locked,
  output logic       sys_reset_n,
  output logic       ready,
  output logic       us_tick,
  output logic [7:0] lock_loss_count
);

  localparam logic [15:0] STABLE_LAST = 16'(LOCK_STABLE - 1);
  localparam logic [15:0] HOLD_LAST   = 16'(RESET_HOLD - 1);
  localparam logic [15:0] TICK_LAST   = 16'(TICK_DIV - 1);

  logic        locked_s;
  seq_state_e  state;
  seq_state_e  next_state;
  logic [15:0] cnt;
  logic [15:0] cnt_next;
  logic [15:0] div;
  logic        run_stays;

  // The only place the raw lock input is sampled.
  sync_2ff u_lock_sync (
    .clk   (global_clock),
    .rst_n (reset_n),
    .d     (locked),
    .q     (locked_s)
  );

  // Next-state and shared counter logic. A low synchronized lock is checked
  // before any terminal count so a dropout always wins and restarts the
  // debounce. The counter returns to 0 whenever it is not actively counting,
  // which gives every phase a clean start.
  always_comb begin
    next_state = state;
    cnt_next   = '0;
    case (state)
      WAIT_LOCK: begin
        if (locked_s) next_state = STABILIZE;
      end
      STABILIZE: begin
        if (!locked_s)                next_state = WAIT_LOCK;
        else if (cnt == STABLE_LAST)  next_state = HOLD;
        else                          cnt_next   = cnt + 16'd1;
      end
      HOLD: begin
        if (!locked_s)              next_state = WAIT_LOCK;
        else if (cnt == HOLD_LAST)  next_state = RUN;
        else                        cnt_next   = cnt + 16'd1;
      end
      RUN: begin
        if (!locked_s) next_state = WAIT_LOCK;
      end
      default: next_state = WAIT_LOCK;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge global_clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= WAIT_LOCK;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
    end
  end

  assign ready     = (state == RUN);
  assign run_stays = (state == RUN) && (next_state == RUN);

  // sys_reset_n is registered from next_state so it changes on exactly the
  // edge the FSM enters or leaves RUN, and never glitches.
  always_ff @(posedge global_clock or negedge reset_n) begin
    if (!reset_n) begin
      sys_reset_n <= 1'b0;
    end else begin
      sys_reset_n <= (next_state == RUN);
    end
  end

  // Microsecond divider. It sits at 0 on the entry edge and only counts on
  // edges where RUN is kept, so the registered pulse lands TICK_DIV cycles
  // after entry. Leaving RUN clears both divider and pulse on that same edge,
  // so the tick can never be seen outside RUN.
  always_ff @(posedge global_clock or negedge reset_n) begin
    if (!reset_n) begin
      div     <= '0;
      us_tick <= 1'b0;
    end else if (!run_stays) begin
      div     <= '0;
      us_tick <= 1'b0;
    end else if (div == TICK_LAST) begin
      div     <= '0;
      us_tick <= 1'b1;
    end else begin
      div     <= div + 16'd1;
      us_tick <= 1'b0;
    end
  end

  // Lock-loss counter. Only a drop out of RUN counts; dropouts during the
  // debounce or hold phases are normal start-up behaviour. Cleared only by
  // reset_n.
  always_ff @(posedge global_clock or negedge reset_n) begin
    if (!reset_n) begin
      lock_loss_count <= '0;
    end else if ((state == RUN) && !locked_s && (lock_loss_count != 8'hFF)) begin
      lock_loss_count <= lock_loss_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_reset_sequencer
// Self-checking bench for reset_sequencer with LOCK_STABLE=4, RESET_HOLD=2,
// TICK_DIV=3. Expected outputs are pushed to a queue as each cycle's stimulus
// is driven and popped and compared one time unit after the clock edge.
// The reference model works purely from the history of sampled lock values:
// the outputs after edge n depend on how many consecutive high samples ended
// at edge n-2.
// ---------------------------------------------------------------------------
module tb_reset_sequencer;

  localparam int LS     = 4;
  localparam int RH     = 2;
  localparam int TD     = 3;
  localparam int RUN_AT = LS + RH + 1;

  typedef struct {
    logic       sys_reset_n;
    logic       ready;
    logic       us_tick;
    logic [7:0] lock_loss_count;
  } exp_t;

  typedef struct {
    logic locked;
    exp_t exp;
  } vec_t;

  logic       global_clock = 1'b0;
  logic       reset_n;
  logic       locked;
  logic       sys_reset_n;
  logic       ready;
  logic       us_tick;
  logic [7:0] lock_loss_count;

  exp_t sb_q[$];
  vec_t vec[20];
  int   compared   = 0;
  int   mismatched = 0;

  int   st1;
  int   st2;
  logic m_ready;
  int   m_count;

  reset_sequencer #(
    .LOCK_STABLE (LS),
    .RESET_HOLD  (RH),
    .TICK_DIV    (TD)
  ) dut (
    .global_clock    (global_clock),
    .reset_n         (reset_n),
    .locked          (locked),
    .sys_reset_n     (sys_reset_n),
    .ready           (ready),
    .us_tick         (us_tick),
    .lock_loss_count (lock_loss_count)
  );

  // 10 time-unit clock
  always #5 global_clock = ~global_clock;

  // Hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic exp_t mk(input logic sr, input logic rd, input logic tk,
                              input logic [7:0] c);
    exp_t e;
    e.sys_reset_n     = sr;
    e.ready           = rd;
    e.us_tick         = tk;
    e.lock_loss_count = c;
    return e;
  endfunction

  function automatic vec_t mv(input logic lk, input logic sr, input logic rd,
                              input logic tk, input logic [7:0] c);
    vec_t v;
    v.locked = lk;
    v.exp    = mk(sr, rd, tk, c);
    return v;
  endfunction

  function automatic void modelReset();
    st1     = 0;
    st2     = 0;
    m_ready = 1'b0;
    m_count = 0;
  endfunction

  // Advance the model by one clock edge with lock value lk sampled on it.
  function automatic exp_t modelStep(input logic lk);
    exp_t e;
    int   nxt;
    logic r;
    nxt = lk ? st1 + 1 : 0;
    r   = (st2 >= RUN_AT);
    if (m_ready && !r && m_count < 255) m_count++;
    e.sys_reset_n     = r;
    e.ready           = r;
    e.us_tick         = r && (st2 > RUN_AT) && (((st2 - RUN_AT) % TD) == 0);
    e.lock_loss_count = 8'(m_count);
    m_ready = r;
    st2     = st1;
    st1     = nxt;
    return e;
  endfunction

  task automatic checkField(input string name, input logic [31:0] act,
                            input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic checkOutput(input string tag, input exp_t e);
    checkField({tag, ".sys_reset_n"},     32'(sys_reset_n),     32'(e.sys_reset_n));
    checkField({tag, ".ready"},           32'(ready),           32'(e.ready));
    checkField({tag, ".us_tick"},         32'(us_tick),         32'(e.us_tick));
    checkField({tag, ".lock_loss_count"}, 32'(lock_loss_count), 32'(e.lock_loss_count));
  endtask

  task automatic popCompare(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s.scoreboard: got empty queue, expected an entry", tag);
    end else begin
      e = sb_q.pop_front();
      checkOutput(tag, e);
    end
  endtask

  // Drive lock for one cycle, queue the expectation, compare after the edge.
  task automatic applyStimulus(input string tag, input logic lk, input exp_t e);
    locked = lk;
    sb_q.push_back(e);
    @(posedge global_clock);
    #1;
    popCompare(tag);
  endtask

  task automatic driveCycle(input string tag, input logic lk);
    exp_t e;
    e = modelStep(lk);
    applyStimulus(tag, lk, e);
  endtask

  // Lock dips low and recovers between two sampling edges.
  task automatic glitchCycle(input string tag);
    exp_t e;
    e = modelStep(1'b1);
    sb_q.push_back(e);
    locked = 1'b0;
    #3;
    locked = 1'b1;
    @(posedge global_clock);
    #1;
    popCompare(tag);
  endtask

  // Assert reset_n mid-cycle, check the outputs clear without a clock edge,
  // hold it across one edge, then release away from the edge.
  task automatic asyncReset(input string tag);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput(tag, mk(1'b0, 1'b0, 1'b0, 8'd0));
    @(posedge global_clock);
    #1;
    reset_n = 1'b1;
    modelReset();
  endtask

  initial begin
    vec[0]  = mv(1, 0, 0, 0, 0);
    vec[1]  = mv(1, 0, 0, 0, 0);
    vec[2]  = mv(1, 0, 0, 0, 0);
    vec[3]  = mv(1, 0, 0, 0, 0);
    vec[4]  = mv(1, 0, 0, 0, 0);
    vec[5]  = mv(1, 0, 0, 0, 0);
    vec[6]  = mv(1, 0, 0, 0, 0);
    vec[7]  = mv(1, 0, 0, 0, 0);
    vec[8]  = mv(1, 1, 1, 0, 0);
    vec[9]  = mv(1, 1, 1, 0, 0);
    vec[10] = mv(1, 1, 1, 0, 0);
    vec[11] = mv(1, 1, 1, 1, 0);
    vec[12] = mv(1, 1, 1, 0, 0);
    vec[13] = mv(1, 1, 1, 0, 0);
    vec[14] = mv(1, 1, 1, 1, 0);
    vec[15] = mv(1, 1, 1, 0, 0);
    vec[16] = mv(1, 1, 1, 0, 0);
    vec[17] = mv(1, 1, 1, 1, 0);
    vec[18] = mv(1, 1, 1, 0, 0);
    vec[19] = mv(1, 1, 1, 0, 0);

    reset_n = 1'b0;
    locked  = 1'b0;
    modelReset();
    repeat (2) @(posedge global_clock);
    #1;
    checkOutput("reset_values", mk(1'b0, 1'b0, 1'b0, 8'd0));
    reset_n = 1'b1;

    // Idle with no lock, then lock held from table edge 1
    repeat (3) driveCycle("idle_unlocked", 1'b0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus($sformatf("table_edge%0d", i + 1), vec[i].locked, vec[i].exp);
    end

    // Reset while in RUN, then a lock dropout during STABILIZE
    asyncReset("reset_in_run_a");
    repeat (2) driveCycle("restart_idle", 1'b0);
    repeat (3) driveCycle("stab_lock", 1'b1);
    repeat (3) driveCycle("stab_dropout", 1'b0);
    repeat (12) driveCycle("stab_relock", 1'b1);

    // Lock loss from RUN, then relock
    driveCycle("run_loss", 1'b0);
    repeat (12) driveCycle("run_relock", 1'b1);

    // Unsampled glitches, then a glitch that is sampled
    glitchCycle("glitch_unsampled_a");
    glitchCycle("glitch_unsampled_b");
    repeat (3) driveCycle("glitch_steady", 1'b1);
    driveCycle("glitch_sampled", 1'b0);
    repeat (12) driveCycle("glitch_relock", 1'b1);

    // Repeated lock loss to drive the counter into saturation
    for (int k = 0; k < 300; k++) begin
      driveCycle("sat_loss", 1'b0);
      repeat (10) driveCycle("sat_relock", 1'b1);
    end
    checkField("count_saturated", 32'(lock_loss_count), 32'd255);

    // Reset in RUN clears the saturated counter
    asyncReset("reset_in_run_b");
    repeat (7) driveCycle("to_hold", 1'b1);

    // Reset in HOLD, then the full latency from the restart
    asyncReset("reset_in_hold");
    repeat (14) driveCycle("post_hold_reset", 1'b1);

    compared++;
    if (sb_q.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
